dvi_timing_gen: RTL
===================

Name: dvi_timing_gen

Overview:
Generates raster timing (Hsync, Vsync, DE) and pixel coordinates for the DVI encoder path. It sits directly downstream of the encoder I2C configuration block. It holds all outputs blanked until that block's Done is asserted, then free-runs frame timing. It also reports whether the programmed pixel clock exceeds 65 MHz, so the upstream configuration selects the matching register set.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, Hsync active level
VS_POL, 0, Vsync active level
PIX_CLK_KHZ, 25175, nominal pixel clock; drives Pixel_clk_greater_than_65Mhz

Ports:
Clk  input  1  pixel clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Init_done  input  1  Done from the I2C configuration block
Pixel_clk_greater_than_65Mhz  output  1  constant, 1 if PIX_CLK_KHZ > 65000
Hsync  output  1  horizontal sync, polarity HS_POL
Vsync  output  1  vertical sync, polarity VS_POL
De  output  1  data enable, high in the active region
Pixel_x  output  12  active column; 0 when De=0
Pixel_y  output  12  active line; 0 when De=0
Frame_start  output  1  one-cycle pulse at pixel (0,0) of each frame
Running  output  1  high while in RUN state

Behaviour:
- Interface: one clock; reset is synchronous and active-high (Clk, Reset).
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL likewise. Counters are 12 bits. Elaboration must fail if either total exceeds 4095.
- Horizontal regions by h_cnt: active 0..H_ACTIVE-1, then FP, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], then BP. Vertical regions by v_cnt follow the same layout.
- Counting: h_cnt wraps at H_TOTAL-1 to 0. v_cnt increments only when h_cnt wraps, and wraps at V_TOTAL-1 to 0.
- Output timing: all outputs are registered and aligned with the counters. In the cycle where (h_cnt,v_cnt)=(h,v), De/Hsync/Vsync/Pixel_x/Pixel_y reflect position (h,v).
- De = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- Hsync is active during the h sync region on every line, including vertical blanking lines.
- Vsync is active for all clocks of the lines in the v sync region.
- Frame_start = 1 exactly when h_cnt=0 and v_cnt=0 in RUN.
- State machine:
  - WAIT_INIT: counters held at 0; De=0, Pixel_x=Pixel_y=0, Hsync=!HS_POL, Vsync=!VS_POL, Running=0, Frame_start=0. Init_done=1 → RUN. The first RUN cycle is position (0,0) with Frame_start=1.
  - RUN: free-run.
  - Init_done falls mid-frame: latch a stop request and continue to the end of the frame. On the wrap from (H_TOTAL-1, V_TOTAL-1) go to WAIT_INIT instead of starting a new frame; no partial frames are produced.
  - Init_done returns high before that wrap: the stop request clears and the next frame proceeds normally.
- Reset (any state, any position): next cycle is WAIT_INIT with counters 0 and all outputs at the blanked values above. Pixel_clk_greater_than_65Mhz is constant and unaffected by reset.
- Init_done already high at reset release: RUN entered one cycle later.

Test Plan:
Use small parameters: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), HS_POL=VS_POL=0.
1. Reset 3 cycles, Init_done=0 for 50 cycles → Hsync=Vsync=1, De=0, Running=0 throughout.
2. Raise Init_done → next cycle Frame_start=1, De=1, Pixel_x=0. De high for 8 clocks, low for 6. Hsync low at h=10..12. Frame_start recurs every 112 cycles.
3. Line 5 → De=0 for all 14 clocks. Vsync low for lines 5..6 (28 clocks). Hsync still pulses on those lines.
4. Drop Init_done at (3,2) → frame completes through (13,7), then WAIT_INIT, with no Frame_start. Raise it at (5,6) in a separate run → continuous frames.
5. Assert Reset at (6,3) → next cycle outputs blanked, Running=0. Release with Init_done=1 → Frame_start one cycle later.
6. PIX_CLK_KHZ=65000 → Pixel_clk_greater_than_65Mhz=0. PIX_CLK_KHZ=74250 → 1.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: raster timing (Hsync/Vsync/DE) and pixel coordinates for
// the DVI encoder path, held blanked until the encoder configuration is done.
//
// Ports:
//   Clk                          pixel clock, rising edge
//   Reset                        synchronous, active-high
//   Init_done                    configuration block Done
//   Pixel_clk_greater_than_65Mhz constant, 1 when PIX_CLK_KHZ > 65000
//   Hsync / Vsync                syncs, active level HS_POL / VS_POL
//   De                           data enable, high in the active region
//   Pixel_x / Pixel_y            active coordinates, 0 outside the active area
//   Frame_start                  one-cycle pulse at pixel (0,0) of each frame
//   Running                      high while free-running frame timing
module dvi_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIX_CLK_KHZ = 25175
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Init_done,
    output logic        Pixel_clk_greater_than_65Mhz,
    output logic        Hsync,
    output logic        Vsync,
    output logic        De,
    output logic [11:0] Pixel_x,
    output logic [11:0] Pixel_y,
    output logic        Frame_start,
    output logic        Running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 12-bit counters cannot represent a longer line or frame.
    if (H_TOTAL > 4095) begin : g_h_total_err
        $error("dvi_timing_gen: H_TOTAL exceeds 4095");
    end
    if (V_TOTAL > 4095) begin : g_v_total_err
        $error("dvi_timing_gen: V_TOTAL exceeds 4095");
    end

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;

    logic        run_nxt;
    logic        de_nxt;
    logic        hs_act_nxt;
    logic        vs_act_nxt;
    logic        fs_nxt;

    assign Pixel_clk_greater_than_65Mhz = (PIX_CLK_KHZ > 65000);

    // Next-state and next-position logic.  A stop request is simply the
    // level of Init_done sampled on the last pixel of the frame: dropping it
    // mid-frame lets the frame finish, and raising it again before the wrap
    // cancels the stop.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        unique case (state)
            WAIT_INIT: begin
                h_nxt = '0;
                v_nxt = '0;
                if (Init_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    if (v_cnt == V_LAST) begin
                        v_nxt = '0;
                        if (!Init_done) begin
                            state_nxt = WAIT_INIT;
                        end
                    end else begin
                        v_nxt = v_cnt + 12'd1;
                    end
                end else begin
                    h_nxt = h_cnt + 12'd1;
                end
            end
            default: begin
                state_nxt = WAIT_INIT;
                h_nxt     = '0;
                v_nxt     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next position so that, once registered,
    // they line up with the counters in the same cycle.
    always_comb begin
        run_nxt    = (state_nxt == RUN);
        de_nxt     = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_act_nxt = run_nxt && (h_nxt >= HS_START) && (h_nxt < HS_END);
        vs_act_nxt = run_nxt && (v_nxt >= VS_START) && (v_nxt < VS_END);
        fs_nxt     = run_nxt && (h_nxt == 12'd0) && (v_nxt == 12'd0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= WAIT_INIT;
            h_cnt       <= '0;
            v_cnt       <= '0;
            Hsync       <= ~HS_POL;
            Vsync       <= ~VS_POL;
            De          <= 1'b0;
            Pixel_x     <= '0;
            Pixel_y     <= '0;
            Frame_start <= 1'b0;
            Running     <= 1'b0;
        end else begin
            state       <= state_nxt;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            Hsync       <= hs_act_nxt ? HS_POL : ~HS_POL;
            Vsync       <= vs_act_nxt ? VS_POL : ~VS_POL;
            De          <= de_nxt;
            Pixel_x     <= de_nxt ? h_nxt : 12'd0;
            Pixel_y     <= de_nxt ? v_nxt : 12'd0;
            Frame_start <= fs_nxt;
            Running     <= run_nxt;
        end
    end

endmodule
